// File: rtl/fwft_unpack_pkg.sv
// fwft_unpack_pkg: FSM encoding, header layout and last-beat keep helper shared by the frame unpacker.
package fwft_unpack_pkg;
  typedef enum logic [1:0] {IDLE, PAYLOAD, DISCARD} state_t;
  localparam int HDR_LEN_LSB = 0;
  localparam int MAX_KEEP = 128;
  function automatic int hdr_drop_bit(input int data_width);
    return data_width - 1;
  endfunction
  function automatic logic [MAX_KEEP-1:0] last_keep(input int len, input int b);
    logic [MAX_KEEP-1:0] ones;
    int r;
    ones = '1;
    r = len % b;
    return ones >> (MAX_KEEP - ((r == 0) ? b : r));
  endfunction
endpackage

// File: rtl/fwft_unpack_out_reg.sv
// fwft_unpack_out_reg: single-entry AXI-Stream output register; accepts a new beat whenever empty or draining.
module fwft_unpack_out_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] d_data,
  input  logic [KEEP_WIDTH-1:0] d_keep,
  input  logic                  d_last,
  input  logic                  ready,
  output logic                  can_load,
  output logic [DATA_WIDTH-1:0] data,
  output logic [KEEP_WIDTH-1:0] keep,
  output logic                  last,
  output logic                  valid
);
  assign can_load = ~valid | ready;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data  <= '0;
      keep  <= '0;
      last  <= 1'b0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= d_data;
      keep  <= d_keep;
      last  <= d_last;
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/fwft_frame_unpacker.sv
// fwft_frame_unpacker: strips length headers from an FWFT FIFO stream and emits AXI-Stream frames
// with byte-accurate TKEEP/TLAST, discarding dropped or malformed frames and keeping statistics.
module fwft_frame_unpacker
  import fwft_unpack_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_LEN    = 1522,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   FIFO_DATA,
  input  logic                    FIFO_EMPTY,
  output logic                    FIFO_RD_EN,
  output logic [DATA_WIDTH-1:0]   M_TDATA,
  output logic [DATA_WIDTH/8-1:0] M_TKEEP,
  output logic                    M_TLAST,
  output logic                    M_TVALID,
  input  logic                    M_TREADY,
  output logic                    BUSY,
  output logic [CNT_WIDTH-1:0]    FRAME_CNT,
  output logic [CNT_WIDTH-1:0]    DROP_CNT,
  output logic [CNT_WIDTH-1:0]    ERR_CNT
);
  localparam int B = DATA_WIDTH / 8;
  localparam int DROP_BIT = hdr_drop_bit(DATA_WIDTH);
  localparam logic [LEN_WIDTH:0] ONE = 1;
  state_t state, nxt;
  logic [LEN_WIDTH-1:0] hdr_len;
  logic [LEN_WIDTH:0] rem, words;
  logic [B-1:0] lk_r, hdr_keep;
  logic drop_r, rd, can_load, hdr_pop, load, last_pop, len_zero, len_big;
  assign hdr_len  = FIFO_DATA[HDR_LEN_LSB +: LEN_WIDTH];
  assign words    = ({1'b0, hdr_len} + (LEN_WIDTH+1)'(B - 1)) / (LEN_WIDTH+1)'(B);
  assign hdr_keep = B'(last_keep(int'(hdr_len), B));
  assign len_zero = hdr_len == '0;
  assign len_big  = hdr_len > LEN_WIDTH'(MAX_LEN);
  assign last_pop = rem == ONE;
  assign BUSY     = state != IDLE;
  // Gating with RST keeps the pop strobe low while the block is held in reset.
  assign FIFO_RD_EN = rd & ~RST;
  assign hdr_pop    = FIFO_RD_EN & (state == IDLE);
  assign load       = FIFO_RD_EN & (state == PAYLOAD);
  always_comb begin
    nxt = state;
    rd  = 1'b0;
    unique case (state)
      IDLE: begin
        rd = ~FIFO_EMPTY;
        if (rd) nxt = len_zero ? IDLE : (len_big | FIFO_DATA[DROP_BIT]) ? DISCARD : PAYLOAD;
      end
      PAYLOAD: begin
        rd = ~FIFO_EMPTY & can_load;
        if (rd && last_pop) nxt = IDLE;
      end
      DISCARD: begin
        rd = ~FIFO_EMPTY;
        if (rd && last_pop) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      rem       <= '0;
      lk_r      <= '0;
      drop_r    <= 1'b0;
      FRAME_CNT <= '0;
      DROP_CNT  <= '0;
      ERR_CNT   <= '0;
    end else begin
      state <= nxt;
      if (hdr_pop) begin
        rem    <= words;
        lk_r   <= hdr_keep;
        drop_r <= FIFO_DATA[DROP_BIT] & ~len_big;
      end else if (FIFO_RD_EN) begin
        rem <= rem - ONE;
      end
      if (M_TVALID & M_TREADY & M_TLAST) FRAME_CNT <= FRAME_CNT + CNT_WIDTH'(1);
      if (hdr_pop & (len_zero | len_big)) ERR_CNT <= ERR_CNT + CNT_WIDTH'(1);
      // Oversize discards clear drop_r at the header, so only flagged drops count here.
      if (FIFO_RD_EN & (state == DISCARD) & last_pop & drop_r) DROP_CNT <= DROP_CNT + CNT_WIDTH'(1);
    end
  end
  fwft_unpack_out_reg #(.DATA_WIDTH(DATA_WIDTH), .KEEP_WIDTH(B)) u_out (
    .CLK(CLK),
    .RST(RST),
    .load(load),
    .d_data(FIFO_DATA),
    .d_keep(last_pop ? lk_r : '1),
    .d_last(last_pop),
    .ready(M_TREADY),
    .can_load(can_load),
    .data(M_TDATA),
    .keep(M_TKEEP),
    .last(M_TLAST),
    .valid(M_TVALID)
  );
endmodule

// File: tb/tb_fwft_frame_unpacker.sv
// tb_fwft_frame_unpacker: FWFT FIFO model feeding the unpacker, with a beat scoreboard and counter model.
module tb_fwft_frame_unpacker;
  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;
  logic CLK, RST, FIFO_EMPTY, FIFO_RD_EN, M_TLAST, M_TVALID, M_TREADY, BUSY;
  logic [31:0] FIFO_DATA, M_TDATA, FRAME_CNT, DROP_CNT, ERR_CNT;
  logic [3:0] M_TKEEP;
  logic [31:0] fq[$];
  logic [31:0] pend[$];
  beat_t exp_q[$];
  int vectors = 0, errs = 0;
  int e_frm = 0, e_drop = 0, e_err = 0;
  bit stall_prev = 0, after_last = 0, bp_win = 0;
  int gap = 0, last_gap = 0;
  logic [31:0] sd;
  logic [3:0] sk;
  logic sl;

  fwft_frame_unpacker dut (
    .CLK(CLK), .RST(RST), .FIFO_DATA(FIFO_DATA), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_RD_EN(FIFO_RD_EN),
    .M_TDATA(M_TDATA), .M_TKEEP(M_TKEEP), .M_TLAST(M_TLAST), .M_TVALID(M_TVALID), .M_TREADY(M_TREADY),
    .BUSY(BUSY), .FRAME_CNT(FRAME_CNT), .DROP_CNT(DROP_CNT), .ERR_CNT(ERR_CNT)
  );

  initial CLK = 0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic refresh();
    FIFO_EMPTY = fq.size() == 0;
    FIFO_DATA  = FIFO_EMPTY ? 32'h0 : fq[0];
  endtask

  always @(posedge CLK) begin
    if (FIFO_RD_EN && fq.size() > 0) void'(fq.pop_front());
    #1 refresh();
  end

  task automatic push_frame(input int len, input bit drop, input int nnow);
    int w;
    bit legal;
    logic [31:0] d;
    beat_t b;
    w = (len + 3) / 4;
    legal = len != 0 && len <= 1522;
    fq.push_back({drop, 15'd0, 16'(len)});
    if (!legal) e_err++;
    else if (drop) e_drop++;
    else e_frm++;
    for (int i = 0; i < w; i++) begin
      d = $urandom;
      if (i < nnow) fq.push_back(d);
      else pend.push_back(d);
      if (legal && !drop) begin
        b.d = d;
        b.k = (i == w - 1 && len % 4 != 0) ? 4'((1 << (len % 4)) - 1) : 4'hF;
        b.l = i == w - 1;
        exp_q.push_back(b);
      end
    end
    refresh();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || fq.size() != 0 || BUSY || M_TVALID) && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_done"}, 64'(n < 2000), 64'd1);
    @(posedge CLK);
    #1;
  endtask

  task automatic cnts(input string tag);
    @(negedge CLK);
    chk({tag, "_frame_cnt"}, 64'(FRAME_CNT), 64'(e_frm));
    chk({tag, "_drop_cnt"}, 64'(DROP_CNT), 64'(e_drop));
    chk({tag, "_err_cnt"}, 64'(ERR_CNT), 64'(e_err));
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!M_TVALID && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_valid_seen"}, 64'(M_TVALID), 64'd1);
  endtask

  always @(negedge CLK) begin
    beat_t e;
    if (!RST) begin
      if (stall_prev) begin
        chk("hold_data", 64'(M_TDATA), 64'(sd));
        chk("hold_keep", 64'(M_TKEEP), 64'(sk));
        chk("hold_last", 64'(M_TLAST), 64'(sl));
      end
      if (bp_win && M_TVALID && !M_TREADY) chk("bp_no_pop", 64'(FIFO_RD_EN), 64'd0);
      if (FIFO_EMPTY) chk("rd_on_empty", 64'(FIFO_RD_EN), 64'd0);
      if (M_TVALID && M_TREADY) begin
        chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("tdata", 64'(M_TDATA), 64'(e.d));
          chk("tkeep", 64'(M_TKEEP), 64'(e.k));
          chk("tlast", 64'(M_TLAST), 64'(e.l));
        end
        if (after_last) begin
          last_gap = gap;
          after_last = 0;
        end
        if (M_TLAST) begin
          after_last = 1;
          gap = 0;
        end
      end else if (!M_TVALID) gap++;
      stall_prev = M_TVALID && !M_TREADY;
      sd = M_TDATA;
      sk = M_TKEEP;
      sl = M_TLAST;
    end
  end

  initial begin
    RST = 1;
    M_TREADY = 1;
    refresh();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_tvalid", 64'(M_TVALID), 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_frame_cnt", 64'(FRAME_CNT), 64'd0);
    RST = 0;
    @(posedge CLK);
    #1;

    push_frame(10, 0, 99);
    drain("single");
    cnts("single");

    push_frame(4, 0, 99);
    push_frame(8, 0, 99);
    drain("b2b");
    chk("b2b_gap", 64'(last_gap), 64'd1);
    cnts("b2b");

    push_frame(24, 0, 99);
    wait_valid("bp");
    @(posedge CLK);
    #1;
    M_TREADY = 0;
    bp_win = 1;
    repeat (5) @(posedge CLK);
    #1;
    M_TREADY = 1;
    bp_win = 0;
    drain("bp");
    cnts("bp");

    push_frame(12, 1, 99);
    push_frame(0, 0, 99);
    push_frame(2000, 0, 999);
    push_frame(4, 0, 99);
    drain("drop");
    cnts("drop");

    push_frame(12, 0, 1);
    repeat (7) @(negedge CLK);
    chk("starve_busy", 64'(BUSY), 64'd1);
    chk("starve_tvalid", 64'(M_TVALID), 64'd0);
    @(posedge CLK);
    #1;
    while (pend.size() != 0) fq.push_back(pend.pop_front());
    refresh();
    drain("starve");
    cnts("starve");

    push_frame(16, 0, 99);
    wait_valid("rst");
    #1;
    RST = 1;
    #1;
    chk("mid_rst_tvalid", 64'(M_TVALID), 64'd0);
    chk("mid_rst_tdata", 64'(M_TDATA), 64'd0);
    chk("mid_rst_tkeep", 64'(M_TKEEP), 64'd0);
    chk("mid_rst_tlast", 64'(M_TLAST), 64'd0);
    chk("mid_rst_busy", 64'(BUSY), 64'd0);
    chk("mid_rst_rd_en", 64'(FIFO_RD_EN), 64'd0);
    chk("mid_rst_frame_cnt", 64'(FRAME_CNT), 64'd0);
    chk("mid_rst_drop_cnt", 64'(DROP_CNT), 64'd0);
    chk("mid_rst_err_cnt", 64'(ERR_CNT), 64'd0);
    fq.delete();
    pend.delete();
    exp_q.delete();
    e_frm = 0;
    e_drop = 0;
    e_err = 0;
    stall_prev = 0;
    refresh();
    @(posedge CLK);
    #1;
    RST = 0;
    push_frame(7, 0, 99);
    drain("post_rst");
    cnts("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
